// File: rtl/systolic_mac_pe.sv
`timescale 1ns/1ps
// Systolic multiply-accumulate PE: operand pass-through, 2-stage MAC, requantised result chain.
// Define MAC_ACC_SAT_EN to make the accumulator add saturate and drive sat_flag; otherwise it wraps.
module systolic_mac_pe #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic                     out_valid,
  input  logic                     load_res,
  output logic                     load_busy,
  input  logic                     shift_en,
  input  logic signed [DATA_W-1:0] res_in,
  input  logic                     res_vin,
  output logic signed [DATA_W-1:0] res_out,
  output logic                     res_vout,
  output logic                     sat_flag
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W + 1;
  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [EXT_W-1:0] RND    = (FRAC_BITS > 0) ? (EXT_W'(1) << RND_SH) : EXT_W'(0);
  localparam logic signed [EXT_W-1:0] RQ_MAX = EXT_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] RQ_MIN = ~RQ_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, PEND} state_t;

  state_t                    state_q, state_d;
  logic                      load_take, capture;
  logic                      first_armed_q, tag_first;
  logic                      prod_v_q, prod_first_q;
  logic signed [PROD_W-1:0]  a_ext, b_ext, prod_d, prod_q;
  logic signed [ACC_W-1:0]   acc_q, prod_ext, acc_add;
  logic signed [EXT_W-1:0]   rq_sum, rq_shift;
  logic signed [DATA_W-1:0]  res_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        a_out <= a_in;
        b_out <= b_in;
      end
    end
  end

  // A load closes the running sum, so an input in the same cycle opens the next one.
  assign tag_first = first_armed_q | load_take;
  assign a_ext     = PROD_W'(a_in);
  assign b_ext     = PROD_W'(b_in);
  assign prod_d    = a_ext * b_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_v_q      <= 1'b0;
      prod_first_q  <= 1'b0;
      prod_q        <= '0;
      first_armed_q <= 1'b1;
    end else begin
      prod_v_q      <= in_valid;
      first_armed_q <= in_valid ? 1'b0 : tag_first;
      if (in_valid) begin
        prod_q       <= prod_d;
        prod_first_q <= tag_first;
      end
    end
  end

  assign prod_ext = ACC_W'(prod_q);

`ifdef MAC_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
  logic signed [EXT_W-1:0] sum_ext;
  logic                    clamp;
  logic                    sat_q;

  // The extra top bit disagreeing with the sign bit means the add left the ACC_W range.
  always_comb begin
    sum_ext = EXT_W'(acc_q) + EXT_W'(prod_ext);
    clamp   = sum_ext[ACC_W] != sum_ext[ACC_W-1];
    acc_add = sum_ext[ACC_W-1:0];
    if (clamp) acc_add = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (prod_v_q) begin
      acc_q <= prod_first_q ? prod_ext : acc_add;
      sat_q <= prod_first_q ? 1'b0 : (sat_q | clamp);
    end
  end

  assign sat_flag = sat_q;
`else
  assign acc_add = acc_q + prod_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (prod_v_q) begin
      acc_q <= prod_first_q ? prod_ext : acc_add;
    end
  end

  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A product still in S1 belongs to the closing sum, so the capture waits one cycle for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ACCUM;
      ACCUM:   if (load_res) begin
                 if (prod_v_q)       state_d = PEND;
                 else if (!in_valid) state_d = IDLE;
               end
      PEND:    state_d = (in_valid || (prod_v_q && prod_first_q)) ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_busy = (state_q == PEND);
    load_take = load_res && (state_q != PEND);
    capture   = (state_q == PEND) || (load_res && ((state_q == IDLE) || !prod_v_q));
  end

  always_comb begin
    rq_sum   = EXT_W'(acc_q) + RND;
    rq_shift = rq_sum >>> FRAC_BITS;
    if (rq_shift > RQ_MAX)      res_sat = RQ_MAX[DATA_W-1:0];
    else if (rq_shift < RQ_MIN) res_sat = RQ_MIN[DATA_W-1:0];
    else                        res_sat = rq_shift[DATA_W-1:0];
  end

  // Any load activity this cycle takes priority over the shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_out  <= '0;
      res_vout <= 1'b0;
    end else if (capture) begin
      res_out  <= res_sat;
      res_vout <= 1'b1;
    end else if (shift_en && !load_take) begin
      res_out  <= res_in;
      res_vout <= res_vin;
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
`timescale 1ns/1ps
// Scoreboard bench for systolic_mac_pe: randomized traffic against a per-sum arithmetic model.
module tb_systolic_mac_pe;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 32;
  localparam int FRAC_BITS = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid, load_res, shift_en, res_vin;
  logic signed [DATA_W-1:0] a_in, b_in, res_in;
  logic signed [DATA_W-1:0] a_out, b_out, res_out;
  logic                     out_valid, load_busy, res_vout, sat_flag;

  systolic_mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .a_out(a_out), .b_out(b_out), .out_valid(out_valid),
    .load_res(load_res), .load_busy(load_busy), .shift_en(shift_en),
    .res_in(res_in), .res_vin(res_vin), .res_out(res_out), .res_vout(res_vout),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int                       due;
    logic signed [DATA_W-1:0] res;
    logic                     vout;
    logic                     chk_busy;
    logic                     busy;
  } res_exp_t;

  typedef struct {
    int                       due;
    logic                     ov;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
  } pt_exp_t;

  res_exp_t sb_q[$];
  pt_exp_t  pt_q[$];

  // Reference state: the running sum as a plain integer plus the bookkeeping a load needs.
  longint                   acc_m;
  logic                     armed_m, sat_m, pend_m, prev_iv, prev2_iv;
  logic signed [DATA_W-1:0] a_hold, b_hold;

  localparam longint AMAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACC_W-1));

  function automatic longint acc_add(input longint x, input longint p, output logic clamped);
    longint s;
    s = x + p;
    clamped = 1'b0;
`ifdef MAC_ACC_SAT_EN
    if (s > AMAX) begin s = AMAX; clamped = 1'b1; end
    else if (s < AMIN) begin s = AMIN; clamped = 1'b1; end
`else
    s = s & ((longint'(1) <<< ACC_W) - 1);
    if (s > AMAX) s = s - (longint'(1) <<< ACC_W);
`endif
    return s;
  endfunction

  function automatic logic signed [DATA_W-1:0] requant(input longint v);
    longint rnd, r, rmax, rmin;
    rnd = 0;
    if (FRAC_BITS > 0) rnd = longint'(1) <<< (FRAC_BITS-1);
    rmax = (longint'(1) <<< (DATA_W-1)) - 1;
    rmin = -(longint'(1) <<< (DATA_W-1));
    r = (v + rnd) >>> FRAC_BITS;
    if (r > rmax) r = rmax;
    if (r < rmin) r = rmin;
    return DATA_W'(r);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic modelReset();
    acc_m = 0; armed_m = 1'b1; sat_m = 1'b0; pend_m = 1'b0;
    prev_iv = 1'b0; prev2_iv = 1'b0; a_hold = '0; b_hold = '0;
  endtask

  // Drives one cycle of inputs and records what the DUT must show as a result.
  task automatic applyStimulus(input logic iv, input logic signed [DATA_W-1:0] a,
                               input logic signed [DATA_W-1:0] b, input logic ld, input logic sh,
                               input logic signed [DATA_W-1:0] rin, input logic rv);
    logic     load_ok, shift_ok, cl;
    longint   p;
    res_exp_t e;
    @(posedge clk);
    #1;
    if (!prev_iv && !prev2_iv) checkOutput("sat_flag", sat_flag, sat_m);
    in_valid = iv; a_in = a; b_in = b; load_res = ld; shift_en = sh; res_in = rin; res_vin = rv;
    load_ok  = ld && !pend_m;
    shift_ok = sh && !load_ok && !pend_m;
    if (load_ok) begin
      e = '{due: cyc + (prev_iv ? 2 : 1), res: requant(acc_m), vout: 1'b1, chk_busy: 1'b1, busy: prev_iv};
      sb_q.push_back(e);
    end else if (shift_ok) begin
      e = '{due: cyc + 1, res: rin, vout: rv, chk_busy: 1'b0, busy: 1'b0};
      sb_q.push_back(e);
    end
    if (iv) begin
      p = longint'(a) * longint'(b);
      if (armed_m || load_ok) begin
        acc_m = p; sat_m = 1'b0;
      end else begin
        acc_m = acc_add(acc_m, p, cl);
        sat_m = sat_m | cl;
      end
      armed_m = 1'b0;
      a_hold = a; b_hold = b;
    end else if (load_ok) begin
      armed_m = 1'b1;
    end
    pt_q.push_back('{due: cyc + 1, ov: iv, a: a_hold, b: b_hold});
    pend_m   = load_ok && prev_iv;
    prev2_iv = prev_iv;
    prev_iv  = iv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic doReset(input logic expect_busy);
    @(posedge clk);
    #3;
    if (expect_busy) checkOutput("busy_before_rst", load_busy, 1);
    rst = 1'b1;
    in_valid = 1'b0; a_in = '0; b_in = '0; load_res = 1'b0; shift_en = 1'b0; res_in = '0; res_vin = 1'b0;
    #1;
    checkOutput("rst_a_out", a_out, 0);
    checkOutput("rst_b_out", b_out, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_res_out", res_out, 0);
    checkOutput("rst_res_vout", res_vout, 0);
    checkOutput("rst_load_busy", load_busy, 0);
    checkOutput("rst_sat_flag", sat_flag, 0);
    sb_q.delete();
    pt_q.delete();
    modelReset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: compares whatever the scoreboard says is due on this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb_q.size() > 0) begin
        if (sb_q[0].chk_busy && (sb_q[0].due == cyc + 1))
          checkOutput("load_busy", load_busy, sb_q[0].busy);
        if (sb_q[0].due == cyc) begin
          checkOutput("res_out", res_out, sb_q[0].res);
          checkOutput("res_vout", res_vout, sb_q[0].vout);
          void'(sb_q.pop_front());
        end else if (sb_q[0].due < cyc) begin
          checkOutput("res_missed_cycle", cyc, sb_q[0].due);
          void'(sb_q.pop_front());
        end
      end
      if (pt_q.size() > 0 && pt_q[0].due <= cyc) begin
        checkOutput("out_valid", out_valid, pt_q[0].ov);
        checkOutput("a_out", a_out, pt_q[0].a);
        checkOutput("b_out", b_out, pt_q[0].b);
        void'(pt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic signed [DATA_W-1:0] rnd_operand();
    int v;
    if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 65535) - 32768;
    else v = $urandom_range(0, 600) - 300;
    return DATA_W'(v);
  endfunction

  initial begin
    logic signed [DATA_W-1:0] ra, rb;
    in_valid = 1'b0; a_in = '0; b_in = '0; load_res = 1'b0; shift_en = 1'b0; res_in = '0; res_vin = 1'b0;
    modelReset();
    doReset(1'b0);

    $display("[TB] four products of 256*512, then load");
    repeat (4) applyStimulus(1'b1, 16'sd256, 16'sd512, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(2);

    $display("[TB] load right after last input, with a new-sum input in the load cycle");
    repeat (4) applyStimulus(1'b1, 16'sd256, 16'sd512, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 16'sd256, 16'sd256, 1'b1, 1'b0, '0, 1'b0);
    idle(3);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(2);

    $display("[TB] accumulator overflow with -32768*-32768 twice");
    repeat (2) applyStimulus(1'b1, -16'sd32768, -16'sd32768, 1'b0, 1'b0, '0, 1'b0);
    idle(3);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(2);

    $display("[TB] rounding half up");
    applyStimulus(1'b1, 16'sd1, 16'sd128, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 16'sd1, 16'sd127, 1'b1, 1'b0, '0, 1'b0);
    idle(2);
    applyStimulus(1'b1, -16'sd1, 16'sd128, 1'b1, 1'b0, '0, 1'b0);
    idle(2);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(2);

    $display("[TB] shift chain and load-over-shift");
    applyStimulus(1'b1, 16'sd10, 16'sd256, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 16'sd20, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 16'sd30, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 16'sd0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 16'sd77, 1'b1);
    idle(2);

    $display("[TB] asynchronous reset while a load is pending");
    applyStimulus(1'b1, 16'sd100, 16'sd100, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 16'sd200, 16'sd200, 1'b1, 1'b0, '0, 1'b0);
    doReset(1'b1);
    applyStimulus(1'b1, 16'sd256, 16'sd256, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      ra = rnd_operand();
      rb = rnd_operand();
      applyStimulus(1'($urandom_range(0, 1)), ra, rb, ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 7) == 0), DATA_W'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)));
    end
    idle(4);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle(4);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", sb_q.size() + pt_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
